// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: col/row counters with registered
// sync, blanking and strobe flags, frame counter and synchronous restart.
module vga_timing_gen #(
  parameter int H_ACTIVE  = 800,
  parameter int H_FP      = 56,
  parameter int H_SYNC    = 120,
  parameter int H_BP      = 64,
  parameter int V_ACTIVE  = 600,
  parameter int V_FP      = 37,
  parameter int V_SYNC    = 6,
  parameter int V_BP      = 23,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int COL_W     = 12,
  parameter int ROW_W     = 11,
  parameter int FRAME_W   = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               pix_en,
  input  logic               restart_req,
  output logic               restart_ack,
  output logic [COL_W-1:0]   col,
  output logic [ROW_W-1:0]   row,
  output logic               visible,
  output logic               hsync,
  output logic               vsync,
  output logic               vblank,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [COL_W-1:0] H_LAST   = COL_W'(H_TOTAL - 1);
  localparam logic [COL_W-1:0] H_ACT    = COL_W'(H_ACTIVE);
  localparam logic [COL_W-1:0] H_HS_BEG = COL_W'(H_ACTIVE + H_FP);
  localparam logic [COL_W-1:0] H_HS_END = COL_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [ROW_W-1:0] V_LAST   = ROW_W'(V_TOTAL - 1);
  localparam logic [ROW_W-1:0] V_ACT    = ROW_W'(V_ACTIVE);
  localparam logic [ROW_W-1:0] V_VS_BEG = ROW_W'(V_ACTIVE + V_FP);
  localparam logic [ROW_W-1:0] V_VS_END = ROW_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
      longint'(H_TOTAL - 1) >= (64'sd1 <<< COL_W) ||
      longint'(V_TOTAL - 1) >= (64'sd1 <<< ROW_W) ||
      FRAME_W < 1) begin : g_param_err
    $error("vga_timing_gen: invalid timing or width parameters");
  end

  logic [COL_W-1:0]   r_col;
  logic [ROW_W-1:0]   r_row;
  logic [FRAME_W-1:0] r_frame_cnt;
  logic               r_ack, r_visible, r_hsync, r_vsync, r_vblank;
  logic               r_line_start, r_frame_start;

  logic [COL_W-1:0] w_col_nxt;
  logic [ROW_W-1:0] w_row_nxt;
  logic             w_frame_wrap;

  // Flags are computed from the next position so they land in the same
  // cycle as the col/row they describe.
  always_comb begin
    w_col_nxt    = r_col;
    w_row_nxt    = r_row;
    w_frame_wrap = 1'b0;
    if (restart_req) begin
      w_col_nxt = '0;
      w_row_nxt = '0;
    end else if (pix_en) begin
      if (r_col == H_LAST) begin
        w_col_nxt = '0;
        if (r_row == V_LAST) begin
          w_row_nxt    = '0;
          w_frame_wrap = 1'b1;
        end else begin
          w_row_nxt = r_row + 1'b1;
        end
      end else begin
        w_col_nxt = r_col + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_col         <= '0;
      r_row         <= '0;
      r_frame_cnt   <= '0;
      r_ack         <= 1'b0;
      r_visible     <= 1'b1;
      r_hsync       <= ~HSYNC_POL;
      r_vsync       <= ~VSYNC_POL;
      r_vblank      <= 1'b0;
      r_line_start  <= 1'b1;
      r_frame_start <= 1'b1;
    end else begin
      r_col         <= w_col_nxt;
      r_row         <= w_row_nxt;
      r_ack         <= restart_req;
      if (w_frame_wrap) r_frame_cnt <= r_frame_cnt + 1'b1;
      r_visible     <= (w_col_nxt < H_ACT) && (w_row_nxt < V_ACT);
      r_hsync       <= (w_col_nxt >= H_HS_BEG && w_col_nxt <= H_HS_END) ? HSYNC_POL : ~HSYNC_POL;
      r_vsync       <= (w_row_nxt >= V_VS_BEG && w_row_nxt <= V_VS_END) ? VSYNC_POL : ~VSYNC_POL;
      r_vblank      <= (w_row_nxt >= V_ACT);
      r_line_start  <= (w_col_nxt == '0);
      r_frame_start <= (w_col_nxt == '0) && (w_row_nxt == '0);
    end
  end

  assign col         = r_col;
  assign row         = r_row;
  assign frame_count = r_frame_cnt;
  assign restart_ack = r_ack;
  assign visible     = r_visible;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign vblank      = r_vblank;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a small 8x6 raster (DUT A) and a default-width line with
// a 6-line frame and active-high syncs (DUT B).
module tb_vga_timing_gen;

  typedef struct packed {
    logic [11:0] col;
    logic [10:0] row;
    logic [15:0] fc;
    logic [6:0]  flags;   // {visible, hsync, vsync, vblank, line_start, frame_start, ack}
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic pix_en_a = 1'b0, restart_a = 1'b0;
  logic pix_en_b = 1'b0, restart_b = 1'b0;

  logic [3:0]  col_a;
  logic [2:0]  row_a;
  logic [15:0] fc_a;
  logic        ack_a, vis_a, hs_a, vs_a, vb_a, ls_a, fs_a;
  logic [11:0] col_b;
  logic [10:0] row_b;
  logic [15:0] fc_b;
  logic        ack_b, vis_b, hs_b, vs_b, vb_b, ls_b, fs_b;

  always #5 clock = ~clock;

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
    .COL_W(4), .ROW_W(3), .FRAME_W(16)
  ) u_dut_a (
    .clock(clock), .reset(reset), .pix_en(pix_en_a), .restart_req(restart_a),
    .restart_ack(ack_a), .col(col_a), .row(row_a), .visible(vis_a),
    .hsync(hs_a), .vsync(vs_a), .vblank(vb_a), .line_start(ls_a),
    .frame_start(fs_a), .frame_count(fc_a)
  );

  vga_timing_gen #(
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
  ) u_dut_b (
    .clock(clock), .reset(reset), .pix_en(pix_en_b), .restart_req(restart_b),
    .restart_ack(ack_b), .col(col_b), .row(row_b), .visible(vis_b),
    .hsync(hs_b), .vsync(vs_b), .vblank(vb_b), .line_start(ls_b),
    .frame_start(fs_b), .frame_count(fc_b)
  );

  exp_t qa[$];
  exp_t qb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  int   ma_col = 0, ma_row = 0, ma_fc = 0;
  logic ma_ack = 1'b0;
  int   mb_col = 0, mb_row = 0, mb_fc = 0;

  // Small config: visible col<4,row<3; hsync low at col 5..6; vsync low at row 4.
  function automatic exp_t mk_a(input int c, input int r, input int fc, input logic ack);
    exp_t e;
    e.col   = 12'(c);
    e.row   = 11'(r);
    e.fc    = 16'(fc);
    e.flags = {(c < 4) && (r < 3), !(c == 5 || c == 6), !(r == 4), r >= 3,
               c == 0, (c == 0) && (r == 0), ack};
    return e;
  endfunction

  // Default line: hsync high at col 856..975; vsync high at row 4.
  function automatic exp_t mk_b(input int c, input int r, input int fc);
    exp_t e;
    e.col   = 12'(c);
    e.row   = 11'(r);
    e.fc    = 16'(fc);
    e.flags = {(c < 800) && (r < 3), (c >= 856) && (c <= 975), r == 4, r >= 3,
               c == 0, (c == 0) && (r == 0), 1'b0};
    return e;
  endfunction

  function automatic exp_t got_a();
    return {12'(col_a), 11'(row_a), fc_a, {vis_a, hs_a, vs_a, vb_a, ls_a, fs_a, ack_a}};
  endfunction

  function automatic exp_t got_b();
    return {col_b, row_b, fc_b, {vis_b, hs_b, vs_b, vb_b, ls_b, fs_b, ack_b}};
  endfunction

  task automatic chk(input string nm, input exp_t got, input exp_t exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got col=%0d row=%0d fc=%0d flags=%b, expected col=%0d row=%0d fc=%0d flags=%b",
               nm, $time, got.col, got.row, got.fc, got.flags, exp.col, exp.row, exp.fc, exp.flags);
    end
  endtask

  // Drive one cycle of stimulus and queue what both DUTs must show after the edge.
  task automatic step(input logic pe, input logic rr);
    @(negedge clock);
    pix_en_a  = pe;
    restart_a = rr;
    pix_en_b  = 1'b1;
    if (rr) begin
      ma_col = 0; ma_row = 0; ma_ack = 1'b1;
    end else begin
      ma_ack = 1'b0;
      if (pe) begin
        if (ma_col == 7) begin
          ma_col = 0;
          if (ma_row == 5) begin ma_row = 0; ma_fc++; end
          else ma_row++;
        end else ma_col++;
      end
    end
    if (mb_col == 1039) begin
      mb_col = 0;
      if (mb_row == 5) begin mb_row = 0; mb_fc++; end
      else mb_row++;
    end else mb_col++;
    qa.push_back(mk_a(ma_col, ma_row, ma_fc, ma_ack));
    qb.push_back(mk_b(mb_col, mb_row, mb_fc));
  endtask

  initial begin : monitor
    forever begin
      @(posedge clock);
      #1;
      if (qa.size() > 0) chk("dut_a_vec", got_a(), qa.pop_front());
      if (qb.size() > 0) chk("dut_b_vec", got_b(), qb.pop_front());
    end
  end

  initial begin : stimulus
    int guard;
    repeat (2) @(negedge clock);
    chk("a_reset", got_a(), mk_a(0, 0, 0, 1'b0));
    chk("b_reset", got_b(), mk_b(0, 0, 0));
    reset = 1'b0;

    // Two full small frames plus a bit: col 0..7 wrap, frame_count after (7,5).
    repeat (100) step(1'b1, 1'b0);

    // pix_en toggling: outputs must hold on the idle cycles.
    for (int i = 0; i < 16; i++) step(i[0] == 1'b0, 1'b0);

    // Single-cycle restart seen at (6,2).
    guard = 0;
    while (!(ma_col == 6 && ma_row == 2) && guard < 100) begin step(1'b1, 1'b0); guard++; end
    step(1'b1, 1'b1);
    repeat (3) step(1'b1, 1'b0);

    // Restart on the same edge as the frame wrap.
    guard = 0;
    while (!(ma_col == 7 && ma_row == 5) && guard < 100) begin step(1'b1, 1'b0); guard++; end
    step(1'b1, 1'b1);
    repeat (2) step(1'b1, 1'b0);

    // Held restart, pix_en ignored, resume on first pix_en edge after release.
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);

    // Asynchronous reset mid-line once DUT A shows col 3.
    guard = 0;
    while (ma_col != 3 && guard < 100) begin step(1'b1, 1'b0); guard++; end
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk("a_async_reset", got_a(), mk_a(0, 0, 0, 1'b0));
    chk("b_async_reset", got_b(), mk_b(0, 0, 0));
    @(negedge clock);
    pix_en_a = 1'b0; pix_en_b = 1'b0; restart_a = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    ma_col = 0; ma_row = 0; ma_fc = 0; ma_ack = 1'b0;
    mb_col = 0; mb_row = 0; mb_fc = 0;

    // Full frame of DUT B (1040 x 6) and beyond; DUT A keeps running too.
    repeat (6300) step(1'b1, 1'b0);

    repeat (3) @(negedge clock);
    n_vec++;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d/%0d entries left, expected 0/0", qa.size(), qb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator; successor to the fixed 800x600@72 Hz controller.
- Timing is set by front-porch/sync/back-porch parameters, sync polarity is selectable, and a pixel clock-enable allows pixel rates below the system clock.
- Adds line/frame start strobes, a vblank flag, a frame counter and a synchronous restart handshake that replaces the old asynchronous refresh input.
- Feeds the pixel/sprite renderer and the VGA DAC pins.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 56, horizontal front porch (pixels)
- H_SYNC, 120, hsync pulse width (pixels)
- H_BP, 64, horizontal back porch (pixels)
- V_ACTIVE, 600, visible lines per frame
- V_FP, 37, vertical front porch (lines)
- V_SYNC, 6, vsync pulse width (lines)
- V_BP, 23, vertical back porch (lines)
- HSYNC_POL, 0, active level of hsync (0 = active-low)
- VSYNC_POL, 0, active level of vsync
- COL_W, 12, width of col output; must hold H_TOTAL-1
- ROW_W, 11, width of row output; must hold V_TOTAL-1
- FRAME_W, 16, width of frame_count

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- pix_en  input  1  pixel clock-enable; the raster advances only on cycles where it is 1
- restart_req  input  1  synchronous request to return the raster to (0,0)
- restart_ack  output  1  one-cycle pulse confirming a restart
- col  output  COL_W  current horizontal position
- row  output  ROW_W  current vertical position
- visible  output  1  1 when col<H_ACTIVE and row<V_ACTIVE
- hsync  output  1  horizontal sync, HSYNC_POL when active
- vsync  output  1  vertical sync, VSYNC_POL when active
- vblank  output  1  1 when row>=V_ACTIVE
- line_start  output  1  1 while col==0
- frame_start  output  1  1 while col==0 and row==0
- frame_count  output  FRAME_W  completed-frame counter, wraps

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Defaults give 1040 x 666.
- Reset (asynchronous): col=0, row=0, frame_count=0, restart_ack=0, visible=1, vblank=0, line_start=1, frame_start=1.
  - Sync outputs are held inactive during reset: hsync=~HSYNC_POL, vsync=~VSYNC_POL.
- All outputs are registered. In every cycle, visible/hsync/vsync/vblank/line_start/frame_start describe the col/row values presented in that same cycle; there is no skew between them.
- Advance on pix_en=1:
  - col increments.
  - When col==H_TOTAL-1: col wraps to 0 and row increments.
  - When row==V_TOTAL-1 as well: row wraps to 0 and frame_count increments modulo 2^FRAME_W.
- pix_en=0: every output holds, including strobes. Consumers qualify strobes with pix_en.
- hsync is active for H_ACTIVE+H_FP <= col <= H_ACTIVE+H_FP+H_SYNC-1. Default range: 856..975.
- vsync is active for V_ACTIVE+V_FP <= row <= V_ACTIVE+V_FP+V_SYNC-1. Default range: 637..642.
- Restart:
  - When restart_req=1 at a clock edge (pix_en is ignored), the next cycle shows col=0, row=0 with all flags recomputed, and restart_ack=1 for exactly that one cycle.
  - frame_count is not incremented by a restart.
  - If restart_req is held high, the raster stays at (0,0) and restart_ack stays 1 each cycle.
  - Counting resumes on the first pix_en edge after restart_req falls.
- Simultaneous events:
  - restart_req and a frame wrap on the same edge: restart wins and frame_count does not increment.
  - reset overrides everything.
- Reset asserted mid-line: immediate return to reset values; no partial sync pulse is extended after release.
- There is no state machine beyond the two counters. Comparisons are unsigned against constants derived from the parameters at elaboration time.
- Parameter sanity: every porch and sync value must be >=1; ROW_W/COL_W must hold V_TOTAL-1 and H_TOTAL-1. Violations are elaboration errors.

Test Plan:
- Small configuration: H 4/1/2/1 (H_TOTAL=8), V 3/1/1/1 (V_TOTAL=6), HSYNC_POL=0, pix_en=1. After reset release:
  - col sequence must be 0..7,0.
  - hsync=0 exactly at col 5..6.
  - vsync=0 exactly at row 4.
  - visible only at col<4, row<3.
  - frame_count=1 on the cycle after (7,5).
- pix_en toggling 1,0,1,0 with the small configuration -> col advances once per two clocks; all outputs are stable during pix_en=0 cycles.
- restart_req pulsed for 1 cycle at (6,2) -> next cycle (0,0), restart_ack=1 for one cycle, frame_start=1, frame_count unchanged.
- restart_req asserted on the same edge as the (7,5)->(0,0) wrap -> frame_count does not increment; restart_ack=1.
- Default parameters with HSYNC_POL=1 and VSYNC_POL=1 -> hsync high for exactly 120 clocks per line starting at col 856; vsync high for 6 lines starting at row 637; one frame = 692640 clocks.
- reset asserted asynchronously mid-line at col 3 -> outputs go to reset values before the next edge; after release the sequence restarts from (0,0) with frame_count=0.
